sync_updown_counter: RTL and testbench

//  Parametrised fully synchronous up/down modulo counter; successor to the 4-bit JK counter.
//  All state bits share one clock edge, so there is no ripple skew.

---
 rtl/sync_updown_counter.sv | 118 +++++++++++
 tb/tb_sync_updown_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_updown_counter.sv
// Purpose : fully synchronous up/down modulo counter with load, clear, wrap/saturate mode and cascade output.
// Latency : q, wrap and sat update one clk after the control inputs are sampled; tc is combinational from q/en/up_dn.
// Backpressure: none; en acts as a per-cycle qualifier, and tc drives en of the next stage for a ripple-free cascade.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset (q=0, wrap=0, sat=0)
//   clr       synchronous clear to 0 (highest priority)
//   load      synchronous parallel load of load_val, clamped to MODULO-1
//   load_val  value for load
//   en        count enable
//   up_dn     1 = count up, 0 = count down
//   q         current count (registered), always within 0..MODULO-1
//   q_bar     bitwise complement of q
//   tc        terminal count: en and q at the limit in the current direction
//   wrap      one-cycle pulse on the cycle after a wrap edge
//   sat       level: counter is held at a limit (SAT=1 builds only)
module sync_updown_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16,
    parameter bit SAT    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    // Reject parameter sets that cannot hold the requested count range.
    generate
        if (WIDTH < 1 || MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_params
            $error("sync_updown_counter: MODULO must lie in 2..2**WIDTH and WIDTH must be >= 1");
        end
    endgenerate

    // Highest legal count value.
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULO - 1);
    // MODULO itself may equal 2**WIDTH, so the clamp compare needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == '0);

    // Out-of-range load values pin to the top of the range so q can never leave 0..MODULO-1.
    assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_Q : load_val;

    // Next-state selection: clr > load > en. wrap defaults low so it only
    // ever pulses for the single cycle following a wrapping edge.
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        sat_nxt  = sat;
        if (clr) begin
            q_nxt   = '0;
            sat_nxt = 1'b0;
        end else if (load) begin
            q_nxt   = load_clamped;
            sat_nxt = 1'b0;
        end else if (en) begin
            if (up_dn) begin
                if (!at_max) begin
                    q_nxt   = q + 1'b1;
                    sat_nxt = 1'b0;
                end else if (SAT) begin
                    // Holding at the top; q stays put.
                    sat_nxt = 1'b1;
                end else begin
                    // Explicit wrap even when MODULO==2**WIDTH would overflow naturally.
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_nxt   = q - 1'b1;
                    sat_nxt = 1'b0;
                end else if (SAT) begin
                    sat_nxt = 1'b1;
                end else begin
                    q_nxt    = MAX_Q;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
            sat  <= sat_nxt;
        end
    end

    assign q_bar = ~q;

    // Asserted independently of SAT so a saturating stage still advances the stage above it.
    assign tc = en & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Purpose : directed self-checking bench for sync_updown_counter (wrap, saturate, priority, reset, cascade).
// Latency : inputs driven 1ns after a rising edge, outputs sampled 1ns after the following rising edge.
// Backpressure: not applicable; every wait is a fixed number of clock edges, with a global watchdog.
module tb_sync_updown_counter;

    logic clk;
    logic reset;

    // Instance A: WIDTH=4, MODULO=16, wrap mode
    logic       a_clr, a_load, a_en, a_up;
    logic [3:0] a_lv;
    logic [3:0] a_q, a_qb;
    logic       a_tc, a_wrap, a_sat;

    // Instances B (wrap) and C (saturate), MODULO=10, sharing controls
    logic       s_clr, s_load, s_en, s_up;
    logic [3:0] s_lv;
    logic [3:0] b_q, b_qb, c_q, c_qb;
    logic       b_tc, b_wrap, b_sat, c_tc, c_wrap, c_sat;

    // Cascade E1 -> E2, MODULO=10 each
    logic       e_en, e_clr, e_load, e_up;
    logic [3:0] e_lv;
    logic [3:0] e1_q, e1_qb, e2_q, e2_qb;
    logic       e1_tc, e1_wrap, e1_sat, e2_tc, e2_wrap, e2_sat;

    int n_cmp;
    int n_bad;

    sync_updown_counter #(.WIDTH(4), .MODULO(16), .SAT(1'b0)) u_a (
        .clk(clk), .reset(reset), .clr(a_clr), .load(a_load), .load_val(a_lv),
        .en(a_en), .up_dn(a_up), .q(a_q), .q_bar(a_qb), .tc(a_tc), .wrap(a_wrap), .sat(a_sat)
    );

    sync_updown_counter #(.WIDTH(4), .MODULO(10), .SAT(1'b0)) u_b (
        .clk(clk), .reset(reset), .clr(s_clr), .load(s_load), .load_val(s_lv),
        .en(s_en), .up_dn(s_up), .q(b_q), .q_bar(b_qb), .tc(b_tc), .wrap(b_wrap), .sat(b_sat)
    );

    sync_updown_counter #(.WIDTH(4), .MODULO(10), .SAT(1'b1)) u_c (
        .clk(clk), .reset(reset), .clr(s_clr), .load(s_load), .load_val(s_lv),
        .en(s_en), .up_dn(s_up), .q(c_q), .q_bar(c_qb), .tc(c_tc), .wrap(c_wrap), .sat(c_sat)
    );

    sync_updown_counter #(.WIDTH(4), .MODULO(10), .SAT(1'b0)) u_e1 (
        .clk(clk), .reset(reset), .clr(e_clr), .load(e_load), .load_val(e_lv),
        .en(e_en), .up_dn(e_up), .q(e1_q), .q_bar(e1_qb), .tc(e1_tc), .wrap(e1_wrap), .sat(e1_sat)
    );

    sync_updown_counter #(.WIDTH(4), .MODULO(10), .SAT(1'b0)) u_e2 (
        .clk(clk), .reset(reset), .clr(e_clr), .load(e_load), .load_val(e_lv),
        .en(e1_tc), .up_dn(e_up), .q(e2_q), .q_bar(e2_qb), .tc(e2_tc), .wrap(e2_wrap), .sat(e2_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int eb2[4]  = '{1, 0, 9, 8};
        int ebw2[4] = '{0, 0, 1, 0};
        int ebt2[4] = '{0, 1, 0, 0};
        int ec2[4]  = '{1, 0, 0, 0};
        int ecs2[4] = '{0, 0, 1, 1};
        int ect2[4] = '{0, 1, 1, 1};
        int eb3[3]  = '{9, 0, 1};
        int ebw3[3] = '{0, 1, 0};
        int ecs3[3] = '{0, 1, 1};

        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        a_clr  = 1'b0; a_load = 1'b0; a_lv = 4'd0; a_en = 1'b0; a_up = 1'b1;
        s_clr  = 1'b0; s_load = 1'b0; s_lv = 4'd0; s_en = 1'b0; s_up = 1'b1;
        e_clr  = 1'b0; e_load = 1'b0; e_lv = 4'd0; e_en = 1'b0; e_up = 1'b1;

        // Reset state
        #2;
        chk("rst_q",    a_q,    0);
        chk("rst_qbar", a_qb,   15);
        chk("rst_wrap", a_wrap, 0);
        chk("rst_sat",  a_sat,  0);
        chk("rst_tc",   a_tc,   0);
        a_en = 1'b1;
        a_up = 1'b1;
        @(negedge clk);
        reset = 1'b1;

        // Test 1: count up 17 edges, MODULO=16
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("t1_q",    a_q,    k % 16);
            chk("t1_tc",   a_tc,   ((k % 16) == 15));
            chk("t1_wrap", a_wrap, (k == 16));
        end

        // Test 5: async reset in the middle of a clock period at q=7
        for (int k = 0; k < 6; k++) tick();
        chk("t5_pre_q", a_q, 7);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_q",    a_q,    0);
        chk("t5_qbar", a_qb,   15);
        chk("t5_wrap", a_wrap, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("t5_first_q", a_q, 1);
        a_en = 1'b0;

        // Test 2: load 2 then count down 4 edges, MODULO=10
        s_load = 1'b1; s_lv = 4'd2; s_en = 1'b0;
        tick();
        chk("t2_load_b", b_q, 2);
        chk("t2_load_c", c_q, 2);
        s_load = 1'b0; s_en = 1'b1; s_up = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_b_q",    b_q,    eb2[k]);
            chk("t2_b_wrap", b_wrap, ebw2[k]);
            chk("t2_b_tc",   b_tc,   ebt2[k]);
            chk("t2_c_q",    c_q,    ec2[k]);
            chk("t2_c_sat",  c_sat,  ecs2[k]);
            chk("t2_c_tc",   c_tc,   ect2[k]);
            chk("t2_c_wrap", c_wrap, 0);
        end

        // Test 3: load 8, count up 3 edges, then one down
        s_load = 1'b1; s_lv = 4'd8; s_en = 1'b0;
        tick();
        chk("t3_load_b", b_q,   8);
        chk("t3_load_c", c_q,   8);
        chk("t3_sat_clr", c_sat, 0);
        s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_b_q",    b_q,    eb3[k]);
            chk("t3_b_wrap", b_wrap, ebw3[k]);
            chk("t3_b_sat",  b_sat,  0);
            chk("t3_c_q",    c_q,    9);
            chk("t3_c_sat",  c_sat,  ecs3[k]);
        end
        s_up = 1'b0;
        tick();
        chk("t3_down_c_q",   c_q,    8);
        chk("t3_down_c_sat", c_sat,  0);
        chk("t3_down_c_qb",  c_qb,   7);
        chk("t3_down_b_q",   b_q,    0);
        chk("t3_down_b_wrap", b_wrap, 0);

        // Test 4: priority clr > load > en, then clamped load
        s_load = 1'b1; s_en = 1'b0; s_lv = 4'd5;
        tick();
        chk("t4_load5", b_q, 5);
        s_clr = 1'b1; s_load = 1'b1; s_en = 1'b1; s_lv = 4'd3;
        tick();
        chk("t4_clr_b", b_q, 0);
        chk("t4_clr_c", c_q, 0);
        s_clr = 1'b0; s_lv = 4'd12;
        tick();
        chk("t4_clamp_b",  b_q,  9);
        chk("t4_clamp_c",  c_q,  9);
        chk("t4_clamp_qb", b_qb, 6);
        s_load = 1'b0; s_up = 1'b1; s_en = 1'b1;
        tick();
        chk("t4_up_b_q",    b_q,    0);
        chk("t4_up_b_wrap", b_wrap, 1);
        chk("t4_up_c_q",    c_q,    9);
        chk("t4_up_c_sat",  c_sat,  1);
        s_en = 1'b0;
        tick();
        chk("t4_hold_b_q",    b_q,    0);
        chk("t4_hold_b_wrap", b_wrap, 0);
        chk("t4_hold_c_q",    c_q,    9);
        chk("t4_hold_c_sat",  c_sat,  1);
        chk("t4_hold_c_tc",   c_tc,   0);
        s_en = 1'b1;
        #1;
        chk("t4_comb_c_tc", c_tc, 1);
        s_clr = 1'b1;
        tick();
        chk("t4_clr_c_q",   c_q,   0);
        chk("t4_clr_c_sat", c_sat, 0);
        s_clr = 1'b0; s_en = 1'b0;

        // Test 6: two-stage decimal cascade, 100 edges
        e_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("t6_cnt",     e2_q * 10 + e1_q, i % 100);
            chk("t6_tc2",     e2_tc,   ((i % 100) == 99));
            chk("t6_wrap1",   e1_wrap, ((i % 10) == 0));
            chk("t6_wrap2",   e2_wrap, ((i % 100) == 0));
        end
        chk("t6_sat1", e1_sat, 0);
        chk("t6_sat2", e2_sat, 0);
        chk("t6_qb1",  e1_qb,  15);
        chk("t6_qb2",  e2_qb,  15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
